// File: rtl/icache_dm_if.sv
// Fetch-side and refill-side signals of the direct-mapped instruction cache.
// master = fetch stage plus instruction memory, slave = the cache.
interface icache_dm_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_rd;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_data;
  logic                  cpu_hit;
  logic                  cpu_stall;
  logic                  flush;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_ack;

  modport master (
    output cpu_rd, cpu_addr, flush, mem_data, mem_ack,
    input  cpu_data, cpu_hit, cpu_stall, mem_req, mem_addr
  );

  modport slave (
    input  cpu_rd, cpu_addr, flush, mem_data, mem_ack,
    output cpu_data, cpu_hit, cpu_stall, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: same-cycle hits, single-line refill on miss,
// one word per memory handshake, whole-cache flush.
module icache_dm #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 16
) (
  input logic        clk,
  input logic        reset,
  icache_dm_if.slave bus
);
  // state  | meaning
  // IDLE   | lookup; hit served same cycle, miss launches a refill
  // REFILL | fetching the latched line, one word per mem_ack
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] REFILL = 1'b1;

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int LO_W   = OFF_W + 2;
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - LO_W;
  localparam int LINE_W = ADDR_WIDTH - LO_W;

  logic [0:0]            state;
  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES][LINE_WORDS];
  logic [LINE_W-1:0]     line_addr;
  logic [OFF_W-1:0]      beat;
  logic                  flush_pend;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             miss_start;
  logic             beat_wr;
  logic             last_beat;

  assign req_off  = bus.cpu_addr[LO_W-1:2];
  assign req_idx  = bus.cpu_addr[LO_W +: IDX_W];
  assign req_tag  = bus.cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign fill_idx = line_addr[IDX_W-1:0];
  assign fill_tag = line_addr[LINE_W-1 -: TAG_W];

  assign bus.cpu_hit   = (state == IDLE) && bus.cpu_rd && valid[req_idx] &&
                         (tag_mem[req_idx] == req_tag);
  assign bus.cpu_stall = bus.cpu_rd && !bus.cpu_hit;
  assign bus.cpu_data  = data_mem[req_idx][req_off];

  assign miss_start = (state == IDLE) && bus.cpu_stall;
  assign beat_wr    = (state == REFILL) && bus.mem_ack;
  assign last_beat  = beat_wr && (beat == OFF_W'(LINE_WORDS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      valid        <= '0;
      line_addr    <= '0;
      beat         <= '0;
      flush_pend   <= 1'b0;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          // The lookup above already used the pre-flush valid bits.
          if (bus.flush) valid <= '0;
          if (miss_start) begin
            line_addr    <= bus.cpu_addr[ADDR_WIDTH-1:LO_W];
            bus.mem_addr <= {bus.cpu_addr[ADDR_WIDTH-1:LO_W], {LO_W{1'b0}}};
            bus.mem_req  <= 1'b1;
            beat         <= '0;
            state        <= REFILL;
          end
        end
        default: begin
          if (bus.flush) flush_pend <= 1'b1;
          if (beat_wr) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              // A flush seen during the refill leaves the new line invalid too.
              if (flush_pend || bus.flush) valid <= '0;
              else valid[fill_idx] <= 1'b1;
              flush_pend  <= 1'b0;
              bus.mem_req <= 1'b0;
              state       <= IDLE;
            end else begin
              bus.mem_addr <= bus.mem_addr + ADDR_WIDTH'(4);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (beat_wr && !reset) data_mem[fill_idx][beat] <= bus.mem_data;
    if (last_beat && !reset) tag_mem[fill_idx] <= fill_tag;
  end
endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: reference cache model plus constant memory image.
`timescale 1ns/1ps
module tb_icache_dm;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int NL = 16;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          miss;
    int          beats;
    int          stalls;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  icache_dm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  icache_dm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .LINES(NL)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sbq[$];

  bit          ref_valid [NL];
  logic [23:0] ref_tag   [NL];

  int ack_period = 1;
  int req_cyc    = 0;
  bit idle_noise = 0;

  int line_beats = 0;
  int tot_beats  = 0;
  int stall_cnt  = 0;
  bit expect_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return 32'h1000 + {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] lbase(input logic [31:0] a);
    return {a[31:4], 4'b0000};
  endfunction

  // Instruction memory: acks every ack_period-th requested cycle; stray acks when idle.
  initial begin
    bus.mem_ack  = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_req) begin
        bus.mem_ack  = ((req_cyc % ack_period) == ack_period - 1);
        bus.mem_data = bus.mem_ack ? memfn(bus.mem_addr) : 32'hDEADBEEF;
        req_cyc++;
      end else begin
        req_cyc      = 0;
        bus.mem_ack  = idle_noise && ($urandom_range(0, 1) == 1);
        bus.mem_data = $urandom;
      end
    end
  end

  // Monitor: checks refill beats as they happen and pops one expectation per hit.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        line_beats = 0; tot_beats = 0; stall_cnt = 0; expect_gap = 0;
      end else begin
        if (expect_gap) begin
          check("mem_req_after_line", bus.mem_req, 0);
          expect_gap = 0;
        end
        if (bus.mem_req && bus.mem_ack) begin
          check("refill_has_fetch", sbq.size() > 0, 1);
          if (sbq.size() > 0)
            check("mem_addr", bus.mem_addr, lbase(sbq[0].addr) + 32'(4 * line_beats));
          line_beats++;
          tot_beats++;
          if (line_beats == LW) begin
            line_beats = 0;
            expect_gap = 1;
          end
        end
        if (bus.cpu_rd) begin
          if (bus.cpu_hit) begin
            check("hit_stall", bus.cpu_stall, 0);
            check("hit_mem_req", bus.mem_req, 0);
            check("hit_has_fetch", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
              e = sbq.pop_front();
              check("cpu_data", bus.cpu_data, e.data);
              check("missed", stall_cnt > 0, e.miss);
              check("refill_beats", tot_beats, e.beats);
              if (e.stalls >= 0) check("stall_cycles", stall_cnt, e.stalls);
            end
            stall_cnt = 0;
            tot_beats = 0;
          end else begin
            check("miss_stall", bus.cpu_stall, 1);
            stall_cnt++;
          end
        end else begin
          check("no_rd_outputs", {bus.cpu_hit, bus.cpu_stall}, 0);
        end
      end
    end
  end

  task automatic ref_clear();
    for (int i = 0; i < NL; i++) ref_valid[i] = 0;
  endtask

  task automatic idle(input int n);
    bus.cpu_rd = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush_pulse();
    bus.cpu_rd = 1'b0;
    bus.flush  = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    ref_clear();
  endtask

  // trig: 0 plain, 1 flush at beat 2, 2 reset at beat 2, 3 flush in the first lookup cycle
  task automatic fetch(input logic [31:0] a, input int trig_in);
    exp_t e;
    int   idx = int'(a[7:4]);
    int   trig = trig_in;
    int   cyc = 0;
    bit   hit;
    bit   done = 0;
    bit   fired = 0;
    bit   rst_chk = 0;
    hit = ref_valid[idx] && (ref_tag[idx] == a[31:8]);
    if (hit && (trig == 1 || trig == 2)) trig = 0;
    e.addr   = a;
    e.data   = memfn(a);
    e.miss   = !hit;
    e.beats  = hit ? 0 : LW;
    e.stalls = hit ? 0 : 1 + LW * ack_period;
    if (trig == 1) begin
      e.beats  = 2 * LW;
      e.stalls = 2 * (1 + LW * ack_period);
    end
    if (trig == 2) e.stalls = -1;
    sbq.push_back(e);
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = a;
    bus.flush    = (trig == 3);
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (rst_chk) begin
        check("mem_req_after_reset", bus.mem_req, 0);
        rst_chk = 0;
      end
      if (bus.cpu_hit) done = 1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      if (reset) begin
        reset   = 1'b0;
        rst_chk = 1;
      end
      cyc++;
      if (!done && !fired && (trig == 1 || trig == 2) && line_beats == 2) begin
        fired = 1;
        if (trig == 1) bus.flush = 1'b1;
        else reset = 1'b1;
      end
    end
    check("fetch_completed", done, 1);
    if (!done) sbq.delete();
    if (trig != 0) ref_clear();
    if (!hit) begin
      ref_valid[idx] = 1;
      ref_tag[idx]   = a[31:8];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [23:0] t;
    int          r;
    reset        = 1'b1;
    bus.cpu_rd   = 1'b0;
    bus.cpu_addr = '0;
    bus.flush    = 1'b0;
    ref_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_mem_req", bus.mem_req, 0);
    check("reset_mem_addr", bus.mem_addr, 0);
    @(posedge clk);
    #1;

    // cold miss, then hit in the same line
    fetch(32'h0000_0048, 0);
    fetch(32'h0000_004C, 0);
    // conflict on index 4
    fetch(32'h0000_0140, 0);
    fetch(32'h0000_0040, 0);
    fetch(32'h0000_0144, 0);
    // slow memory
    ack_period = 3;
    fetch(32'h0000_0080, 0);
    fetch(32'h0000_0088, 0);
    ack_period = 1;
    // flush in idle
    fetch(32'h0000_0144, 0);
    idle(1);
    flush_pulse();
    fetch(32'h0000_0140, 0);
    // flush during refill, then plain refetch
    flush_pulse();
    fetch(32'h0000_0040, 1);
    idle(2);
    fetch(32'h0000_0040, 0);
    // reset mid-refill
    flush_pulse();
    fetch(32'h0000_0040, 2);
    fetch(32'h0000_0044, 0);
    // flush in the same cycle as a hit: data served, line gone afterwards
    fetch(32'h0000_0040, 3);
    fetch(32'h0000_0040, 0);

    // randomized traffic
    idle_noise = 1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 3);
      t = (r == 3) ? 24'hFF_FFFF : 24'(r);
      a = {t, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      ack_period = $urandom_range(1, 3);
      r = $urandom_range(0, 19);
      if (r == 0) flush_pulse();
      else if (r == 1) idle($urandom_range(1, 3));
      r = $urandom_range(0, 19);
      fetch(a, (r < 3) ? r + 1 : 0);
    end

    idle(4);
    check("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped instruction cache between the cpu fetch stage and main instruction memory.
- Serves fetches in the same cycle on a hit.
- On a miss, stalls the fetch stage and refills one line from memory, one word per handshake beat.
- Supports a whole-cache invalidate (flush) for self-modifying code and program reload in the test benches.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, instruction word width.
- LINE_WORDS, 4, words per line (power of two, >=2).
- LINES, 16, number of lines (power of two).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_rd  in  1  fetch request this cycle.
- cpu_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- cpu_data  out  DATA_WIDTH  fetched instruction; valid when cpu_hit=1.
- cpu_hit  out  1  request hit; combinational.
- cpu_stall  out  1  fetch must hold; combinational.
- flush  in  1  invalidate all lines.
- mem_req  out  1  refill beat request, registered.
- mem_addr  out  ADDR_WIDTH  word address of current beat, registered.
- mem_data  in  DATA_WIDTH  beat data.
- mem_ack  in  1  beat accepted; mem_data valid this cycle.

Behaviour:
- Address split:
  - offset = [log2(LINE_WORDS)+1:2]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage: per line, a valid bit, a tag and LINE_WORDS data words. Tag/valid/data are readable combinationally.
- Reset (synchronous):
  - State goes to IDLE; all valid bits clear.
  - mem_req=0, mem_addr=0, beat counter=0, pending flush cleared.
  - Data array is not cleared.
- Outputs:
  - cpu_hit = (state==IDLE) & cpu_rd & valid[index] & (tag match).
  - cpu_stall = cpu_rd & ~cpu_hit.
  - cpu_data = data[index][offset] always; it is don't-care when cpu_hit=0.
- States:
  - IDLE:
    - If cpu_rd and miss, latch the line base address (cpu_addr with offset and byte bits zeroed).
    - Set beat=0, mem_req=1, mem_addr=base, and go to REFILL next cycle.
    - A hit stays in IDLE with zero-latency data.
  - REFILL:
    - mem_req held 1.
    - On each cycle with mem_ack=1: write mem_data into data[latched index][beat], increment beat, set mem_addr=base+4*(beat+1).
    - mem_ack=0 cycles change nothing; beats count only on ack.
    - On the ack of beat LINE_WORDS-1:
      - write tag, set valid=1 unless a flush is pending, clear the pending flush;
      - mem_req=0, mem_addr holds its last value, go to IDLE.
    - cpu_stall stays 1 throughout. cpu_addr changes during REFILL are ignored; the latched address is used.
  - The first IDLE cycle after a refill re-looks up the request; a hit on the refilled line gives zero-latency data.
- Flush:
  - In IDLE: all valid bits clear at the clock edge; the same-cycle lookup uses the pre-flush valid bits.
  - In REFILL: latched as pending. The refill runs to completion (memory protocol is never aborted), the refilled line is left invalid, and all other valid bits clear at completion.
- Reset mid-refill: abandons the refill immediately. mem_req drops the next cycle; memory must tolerate a dropped request.
- mem_ack while in IDLE: ignored.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. The beat counter is log2(LINE_WORDS) bits and never exceeds LINE_WORDS-1.

Test Plan:
- Cold miss:
  - Stimulus: after reset, cpu_rd=1, cpu_addr=0x00000048; memory acks every cycle and returns 0x1000+addr.
  - Required: cpu_stall=1, mem_addr 0x40, 0x44, 0x48, 0x4C.
  - Required: the cycle after the 4th ack, cpu_hit=1 and cpu_data=0x00001048.
  - Required: a following fetch of 0x4C hits with 0x0000104C, and mem_req stays 0.
- Conflict:
  - Stimulus: fetch 0x00000140 (index 4, tag 1) after the scenario above.
  - Required: miss with refill 0x140..0x14C.
  - Required: a fetch of 0x40 then misses again and refills.
- Slow memory:
  - Stimulus: mem_ack asserted only every 3rd cycle.
  - Required: exactly 4 data writes, mem_addr advances only on ack, and the stall lasts 12 cycles plus the return cycle.
- Flush in IDLE:
  - Stimulus: with line 0x40 valid, pulse flush for 1 cycle.
  - Required: the next fetch of 0x40 misses and mem_req=1.
- Flush during refill:
  - Stimulus: assert flush at beat 2 of a refill of 0x40.
  - Required: all 4 beats complete, mem_req drops, and a refetch of 0x40 misses again.
- Reset mid-refill:
  - Stimulus: reset for 1 cycle at beat 2.
  - Required: next cycle mem_req=0; a refetch of 0x40 issues a full 4-beat refill starting at 0x40.
